seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Parametrised serial bit-pattern detector with a registered Mealy-style output.
- Default configuration detects "101".
- Runtime-programmable pattern, overlap/non-overlap mode, input-valid qualifier and a saturating match counter.
- Sits on a serial data line as a framing/sync-word detector feeding control logic.

Parameters:
- PAT_LEN, 3, pattern length in bits (2..32).
- RST_PATTERN, 3'b101 (PAT_LEN bits), pattern loaded at reset.
- RST_OVERLAP, 1, overlap mode at reset (1 = overlapping matches allowed).
- CNT_W, 8, match counter width.

Ports:
- clk  input  1  clock, all state changes on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled only when high.
- cfg_load  input  1  one-cycle strobe: load cfg_pattern/cfg_overlap.
- cfg_pattern  input  PAT_LEN  new pattern; MSB is the first bit received.
- cfg_overlap  input  1  new overlap mode.
- cnt_clr  input  1  synchronous clear of match_cnt.
- dout  output  1  match pulse, one cycle.
- match_cnt  output  CNT_W  saturating count of matches.
- busy  output  1  high while a partial match is in progress.

Behaviour:
- Reset (reset_n low, async):
  - pattern register = RST_PATTERN; overlap register = RST_OVERLAP.
  - History shift register = 0; fill count = 0.
  - dout = 0; match_cnt = 0; busy = 0.
- Internal state:
  - hist: PAT_LEN-1 most recent accepted bits.
  - fill: 0..PAT_LEN-1, number of valid bits in hist.
- Accepted bit (din_valid=1, cfg_load=0) at a rising edge:
  - cand = {hist, din}.
  - hit = (fill == PAT_LEN-1) && (cand == pattern).
- On hit:
  - dout <= 1 at the same edge, so dout is high for exactly the following cycle. Latency is 0 cycles after the edge sampling the final bit.
  - match_cnt increments, saturating at 2^CNT_W-1.
  - Overlap=1: hist <= cand[PAT_LEN-2:0], fill stays PAT_LEN-1. Overlapping matches are permitted.
  - Overlap=0: hist <= 0, fill <= 0. The next match needs PAT_LEN fresh bits.
- On an accepted bit with no hit:
  - hist <= cand[PAT_LEN-2:0]; fill <= min(fill+1, PAT_LEN-1); dout <= 0.
- din_valid=0: hist, fill and match_cnt hold; dout <= 0. Gaps do not break a partial match.
- cfg_load=1 (has priority over din):
  - pattern <= cfg_pattern; overlap <= cfg_overlap.
  - hist <= 0; fill <= 0; dout <= 0.
  - The bit presented that cycle is discarded.
- cnt_clr=1: match_cnt <= 0. If a hit occurs the same cycle, match_cnt <= 1 (clear then count). dout is unaffected by cnt_clr.
- busy = (fill != 0) && (partial prefix of hist matches pattern prefix). Combinational from registers, no din dependency.
- Pattern of all zeros or all ones is legal. With fill saturated, overlap mode then flags every consecutive accepted matching bit.
- reset_n asserted mid-pattern: everything returns to reset values immediately. After release, the first match requires PAT_LEN full bits.

Test Plan:
- Defaults, din stream 1,0,1,0,1 all valid → dout pulses after the 3rd and 5th bits (overlap), match_cnt=2.
- cfg_load pattern 101, cfg_overlap=0, same stream → single pulse after 3rd bit, match_cnt=1. Add bits 0,1 → second pulse after 7th bit, match_cnt=2.
- Stream 1,0 then din_valid=0 for 4 cycles, then 1 → dout pulses after the final bit. dout stays 0 during the gap.
- PAT_LEN=8, load 8'hA5, send 0xA5 MSB-first → one pulse after 8th bit. Sending 0xA4 → no pulse.
- CNT_W=2, overlap, pattern 11, send eight 1s → 7 pulses, match_cnt saturates at 3. cnt_clr coincident with a hit → match_cnt=1.
- Drop reset_n after 1,0 of pattern 101, release, send 1 → no pulse. Then 0,1 → pulse. cfg_load mid-pattern discards partial history likewise.

Source files
------------

// File: rtl/seq_detect_param_if.sv
// Serial pattern-detector bus: data/valid, runtime config and match status.
//   din, din_valid            serial bit and its qualifier
//   cfg_load, cfg_pattern,
//   cfg_overlap               one-cycle config strobe and new settings
//   cnt_clr                   synchronous clear of the match counter
//   dout, match_cnt, busy     match pulse, saturating count, partial-match flag
interface seq_detect_param_if #(
  parameter int unsigned PAT_LEN = 3,
  parameter int unsigned CNT_W   = 8
);
  logic               din;
  logic               din_valid;
  logic               cfg_load;
  logic [PAT_LEN-1:0] cfg_pattern;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               dout;
  logic [CNT_W-1:0]   match_cnt;
  logic               busy;

  modport master (
    output din, din_valid, cfg_load, cfg_pattern, cfg_overlap, cnt_clr,
    input  dout, match_cnt, busy
  );

  modport slave (
    input  din, din_valid, cfg_load, cfg_pattern, cfg_overlap, cnt_clr,
    output dout, match_cnt, busy
  );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial bit-pattern detector with registered Mealy match pulse.
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      slave side of seq_detect_param_if (data in, config, status out)
module seq_detect_param #(
  parameter int unsigned        PAT_LEN     = 3,
  parameter logic [PAT_LEN-1:0] RST_PATTERN = PAT_LEN'(3'b101),
  parameter bit                 RST_OVERLAP = 1'b1,
  parameter int unsigned        CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  seq_detect_param_if.slave bus
);

  localparam int unsigned      HIST_W   = PAT_LEN - 1;
  localparam int unsigned      FILL_W   = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [PAT_LEN-1:0] pattern_q, pattern_d;
  logic               overlap_q, overlap_d;
  logic [HIST_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               dout_q, dout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PAT_LEN-1:0] cand;
  logic               hit;
  logic [HIST_W-1:0]  hist_mask;
  logic [PAT_LEN-1:0] pat_prefix;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q <= RST_PATTERN;
      overlap_q <= RST_OVERLAP;
      hist_q    <= '0;
      fill_q    <= '0;
      dout_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pattern_q <= pattern_d;
      overlap_q <= overlap_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      dout_q    <= dout_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state: config load wins over data; clear-then-count on the counter
  always_comb begin
    pattern_d = pattern_q;
    overlap_d = overlap_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    dout_d    = 1'b0;
    cnt_d     = bus.cnt_clr ? '0 : cnt_q;
    cand      = {hist_q, bus.din};
    hit       = 1'b0;

    if (bus.cfg_load) begin
      pattern_d = bus.cfg_pattern;
      overlap_d = bus.cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
    end else if (bus.din_valid) begin
      hit = (fill_q == FILL_MAX) && (cand == pattern_q);
      if (hit) begin
        dout_d = 1'b1;
        if (cnt_d != CNT_MAX) cnt_d = cnt_d + CNT_W'(1);
        if (overlap_q) begin
          hist_d = cand[HIST_W-1:0];
        end else begin
          hist_d = '0;
          fill_d = '0;
        end
      end else begin
        hist_d = cand[HIST_W-1:0];
        if (fill_q != FILL_MAX) fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  // Partial match: the fill newest bits of hist equal the first fill pattern bits
  always_comb begin
    hist_mask  = HIST_W'((64'd1 << fill_q) - 64'd1);
    pat_prefix = PAT_LEN'(pattern_q >> (PAT_LEN - 32'(fill_q)));
  end

  assign bus.busy      = (fill_q != '0) &&
                         ((hist_q & hist_mask) == HIST_W'(pat_prefix));
  assign bus.dout      = dout_q;
  assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  seq_detect_param_if #(.PAT_LEN(3), .CNT_W(8)) bus0 ();
  seq_detect_param_if #(.PAT_LEN(8), .CNT_W(8)) bus1 ();
  seq_detect_param_if #(.PAT_LEN(2), .CNT_W(2)) bus2 ();

  seq_detect_param #(.PAT_LEN(3), .RST_PATTERN(3'b101), .RST_OVERLAP(1'b1), .CNT_W(8))
    u_dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
  seq_detect_param #(.PAT_LEN(8), .RST_PATTERN(8'h3C), .RST_OVERLAP(1'b1), .CNT_W(8))
    u_dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
  seq_detect_param #(.PAT_LEN(2), .RST_PATTERN(2'b11), .RST_OVERLAP(1'b1), .CNT_W(2))
    u_dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: last accepted bits as a plain word plus a count of bits
  // accepted since the last history clear.
  int          m_len  [3] = '{3, 8, 2};
  int          m_cmax [3] = '{255, 255, 3};
  logic [31:0] m_rpat [3] = '{32'h5, 32'h3C, 32'h3};
  logic [31:0] m_pat  [3];
  bit          m_ovl  [3];
  logic [31:0] m_hv   [3];
  int          m_hn   [3];
  int          m_cnt  [3];
  bit          m_dout [3];

  function automatic logic [31:0] lmask(input int n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

  function automatic bit exp_busy(input int m);
    int f;
    f = (m_hn[m] < m_len[m] - 1) ? m_hn[m] : m_len[m] - 1;
    if (f == 0) return 1'b0;
    return (m_hv[m] & lmask(f)) == (m_pat[m] >> (m_len[m] - f));
  endfunction

  function automatic logic [31:0] obs_cnt(input int m);
    case (m)
      0:       return 32'(bus0.match_cnt);
      1:       return 32'(bus1.match_cnt);
      default: return 32'(bus2.match_cnt);
    endcase
  endfunction

  function automatic logic obs_dout(input int m);
    case (m)
      0:       return bus0.dout;
      1:       return bus1.dout;
      default: return bus2.dout;
    endcase
  endfunction

  function automatic logic obs_busy(input int m);
    case (m)
      0:       return bus0.busy;
      1:       return bus1.busy;
      default: return bus2.busy;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int m, input string tag);
    chk($sformatf("%s_d%0d_dout", tag, m), 32'(obs_dout(m)), 32'(m_dout[m]));
    chk($sformatf("%s_d%0d_cnt", tag, m), obs_cnt(m), 32'(m_cnt[m]));
    chk($sformatf("%s_d%0d_busy", tag, m), 32'(obs_busy(m)), 32'(exp_busy(m)));
  endtask

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      m_pat[m] = m_rpat[m]; m_ovl[m] = 1'b1; m_hv[m] = '0;
      m_hn[m] = 0; m_cnt[m] = 0; m_dout[m] = 1'b0;
    end
  endtask

  task automatic model_step(input int m, input bit d, input bit v, input bit ld,
                            input logic [31:0] lp, input bit lo, input bit clr);
    m_dout[m] = 1'b0;
    if (clr) m_cnt[m] = 0;
    if (ld) begin
      m_pat[m] = lp & lmask(m_len[m]); m_ovl[m] = lo; m_hv[m] = '0; m_hn[m] = 0;
    end else if (v) begin
      m_hv[m] = (m_hv[m] << 1) | 32'(d);
      if (m_hn[m] < 64) m_hn[m]++;
      if (m_hn[m] >= m_len[m] && (m_hv[m] & lmask(m_len[m])) == m_pat[m]) begin
        m_dout[m] = 1'b1;
        if (m_cnt[m] < m_cmax[m]) m_cnt[m]++;
        if (!m_ovl[m]) begin m_hv[m] = '0; m_hn[m] = 0; end
      end
    end
  endtask

  task automatic idle_all();
    bus0.din = 0; bus0.din_valid = 0; bus0.cfg_load = 0; bus0.cfg_pattern = '0; bus0.cfg_overlap = 0; bus0.cnt_clr = 0;
    bus1.din = 0; bus1.din_valid = 0; bus1.cfg_load = 0; bus1.cfg_pattern = '0; bus1.cfg_overlap = 0; bus1.cnt_clr = 0;
    bus2.din = 0; bus2.din_valid = 0; bus2.cfg_load = 0; bus2.cfg_pattern = '0; bus2.cfg_overlap = 0; bus2.cnt_clr = 0;
  endtask

  task automatic step(input int m, input bit d, input bit v, input bit ld,
                      input logic [31:0] lp, input bit lo, input bit clr, input string tag);
    @(negedge clk);
    idle_all();
    case (m)
      0: begin bus0.din = d; bus0.din_valid = v; bus0.cfg_load = ld; bus0.cfg_pattern = 3'(lp); bus0.cfg_overlap = lo; bus0.cnt_clr = clr; end
      1: begin bus1.din = d; bus1.din_valid = v; bus1.cfg_load = ld; bus1.cfg_pattern = 8'(lp); bus1.cfg_overlap = lo; bus1.cnt_clr = clr; end
      default: begin bus2.din = d; bus2.din_valid = v; bus2.cfg_load = ld; bus2.cfg_pattern = 2'(lp); bus2.cfg_overlap = lo; bus2.cnt_clr = clr; end
    endcase
    @(posedge clk);
    model_step(m, d, v, ld, lp, lo, clr);
    #1;
    check_inst(m, tag);
  endtask

  task automatic bit_in(input int m, input bit d, input string tag);
    step(m, d, 1'b1, 1'b0, '0, 1'b0, 1'b0, tag);
  endtask

  task automatic load(input int m, input logic [31:0] p, input bit o, input string tag);
    step(m, 1'b1, 1'b1, 1'b1, p, o, 1'b0, tag);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    idle_all();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    for (int m = 0; m < 3; m++) check_inst(m, tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] byte_v;
    reset_n = 1'b0;
    idle_all();
    model_reset();
    #12;
    for (int m = 0; m < 3; m++) check_inst(m, "reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Defaults, overlapping 101 in 10101
    bit_in(0, 1, "t1"); bit_in(0, 0, "t1"); bit_in(0, 1, "t1_hit3");
    chk("t1_pulse3", 32'(bus0.dout), 32'd1);
    bit_in(0, 0, "t1"); bit_in(0, 1, "t1_hit5");
    chk("t1_cnt2", obs_cnt(0), 32'd2);

    // Non-overlap
    load(0, 32'h5, 1'b0, "t2_load");
    bit_in(0, 1, "t2"); bit_in(0, 0, "t2"); bit_in(0, 1, "t2");
    bit_in(0, 0, "t2"); bit_in(0, 1, "t2_nohit5");
    chk("t2_nopulse5", 32'(bus0.dout), 32'd0);
    bit_in(0, 0, "t2"); bit_in(0, 1, "t2_hit7");
    chk("t2_cnt", obs_cnt(0), 32'd4);

    // Valid gaps keep the partial match
    load(0, 32'h5, 1'b1, "t3_load");
    bit_in(0, 1, "t3"); bit_in(0, 0, "t3");
    for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, "t3_gap");
    chk("t3_gap_busy", 32'(bus0.busy), 32'd1);
    bit_in(0, 1, "t3_hit");
    chk("t3_pulse", 32'(bus0.dout), 32'd1);

    // 8-bit pattern A5, then A4 after a reload
    load(1, 32'hA5, 1'b1, "t4_load");
    byte_v = 8'hA5;
    for (int i = 7; i >= 0; i--) bit_in(1, byte_v[i], "t4_a5");
    chk("t4_pulse", 32'(bus1.dout), 32'd1);
    load(1, 32'hA5, 1'b1, "t4_reload");
    byte_v = 8'hA4;
    for (int i = 7; i >= 0; i--) bit_in(1, byte_v[i], "t4_a4");
    chk("t4_cnt", obs_cnt(1), 32'd1);

    // Saturating 2-bit counter, pattern 11
    for (int i = 0; i < 8; i++) bit_in(2, 1'b1, "t5_ones");
    chk("t5_sat", obs_cnt(2), 32'd3);
    step(2, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1, "t5_clrhit");
    chk("t5_clrhit_cnt", obs_cnt(2), 32'd1);

    // Reset and cfg_load mid-pattern discard history
    load(0, 32'h5, 1'b1, "t6_load");
    bit_in(0, 1, "t6"); bit_in(0, 0, "t6");
    pulse_reset("t6_rst");
    bit_in(0, 1, "t6_after"); bit_in(0, 0, "t6"); bit_in(0, 1, "t6_hit");
    load(0, 32'h5, 1'b1, "t6_load2");
    bit_in(0, 1, "t6"); bit_in(0, 0, "t6");
    load(0, 32'h5, 1'b1, "t6_midload");
    bit_in(0, 1, "t6_nohit");
    chk("t6_nopulse", 32'(bus0.dout), 32'd0);
    bit_in(0, 0, "t6"); bit_in(0, 1, "t6_hit2");

    // Randomised traffic against the model
    for (int i = 0; i < 900; i++) begin
      int m;
      m = int'($urandom_range(0, 2));
      step(m, 1'($urandom), ($urandom_range(0, 9) < 8), ($urandom_range(0, 39) == 0),
           $urandom, 1'($urandom), ($urandom_range(0, 29) == 0), "rand");
      if ($urandom_range(0, 299) == 0) pulse_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
